// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall vector layout, stall patterns and FSM encoding shared by the pipeline controller.
package pipe_ctrl_pkg;
    localparam int STALL_W     = 6;
    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_MEMWB = 4;
    localparam int STALL_WB    = 5;
    // Thermometer patterns: holding a stage also holds everything upstream of it.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard requests into, and stall/flush controls out of, the pipeline controller.
interface pipe_ctrl_if import pipe_ctrl_pkg::*; #(parameter int MC_LEN_W = 6);
    logic                stallreq_id;
    logic                ex_mc_start;
    logic [MC_LEN_W-1:0] ex_mc_len;
    logic                flush_req;
    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic                ex_mc_done;
    logic                busy;
    modport master (output stallreq_id, ex_mc_start, ex_mc_len, flush_req,
                    input  stall, flush, ex_mc_done, busy);
    modport slave  (input  stallreq_id, ex_mc_start, ex_mc_len, flush_req,
                    output stall, flush, ex_mc_done, busy);
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with a multi-cycle EX occupancy FSM.
module pipe_ctrl import pipe_ctrl_pkg::*; #(parameter int MC_LEN_W = 6) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);
    state_t              state;
    logic [MC_LEN_W-1:0] cnt;
    logic                mc_go;
    logic                ex_stall;

    assign mc_go    = bus.ex_mc_start && bus.ex_mc_len != '0;
    assign ex_stall = state == BUSY || (state == IDLE && mc_go);

    // Hazard response is same-cycle; reset and flush both silence every stall.
    assign bus.stall      = (rst || bus.flush_req) ? STALL_NONE :
                            ex_stall ? STALL_EX : bus.stallreq_id ? STALL_ID : STALL_NONE;
    assign bus.flush      = !rst && bus.flush_req;
    assign bus.ex_mc_done = !rst && !bus.flush_req && state == DONE;
    assign bus.busy       = state == BUSY;

    // cnt holds the stalled cycles still owed after the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (bus.flush_req) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (mc_go) begin
                    cnt   <= bus.ex_mc_len - MC_LEN_W'(1);
                    state <= bus.ex_mc_len == MC_LEN_W'(1) ? DONE : BUSY;
                end
                BUSY: begin
                    cnt   <= cnt - MC_LEN_W'(1);
                    state <= cnt == MC_LEN_W'(1) ? DONE : BUSY;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl stall/flush/multi-cycle behaviour.
module tb_pipe_ctrl;
    typedef struct packed {
        logic [5:0] stall;
        logic       flush;
        logic       done;
        logic       busy;
    } exp_t;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    pipe_ctrl_if #(.MC_LEN_W(6)) bus();
    pipe_ctrl #(.MC_LEN_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic drive(input logic sid, input logic st, input logic fr, input logic [5:0] len);
        bus.stallreq_id = sid;
        bus.ex_mc_start = st;
        bus.flush_req   = fr;
        bus.ex_mc_len   = len;
    endtask

    task automatic expect_out(input logic [5:0] es, input logic ef, input logic ed, input logic eb);
        q.push_back(exp_t'({es, ef, ed, eb}));
    endtask

    task automatic check(input string tag);
        exp_t o;
        exp_t e;
        o = exp_t'({bus.stall, bus.flush, bus.ex_mc_done, bus.busy});
        tests++;
        if (q.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, o);
        end else begin
            e = q.pop_front();
            assert (o === e) else begin
                fails++;
                $error("FAIL %s: observed stall/flush/done/busy=%b required=%b", tag, o, e);
            end
        end
    endtask

    // One clock: drive after the edge, check at the falling edge, return just past the next rising edge.
    task automatic step(input logic sid, input logic st, input logic fr, input logic [5:0] len,
                        input logic [5:0] es, input logic ef, input logic ed, input logic eb,
                        input string tag);
        drive(sid, st, fr, len);
        expect_out(es, ef, ed, eb);
        @(negedge clk);
        check(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 6'd4);
        expect_out(6'b000000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_outputs");
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 6'd0);
        rst = 1'b0;

        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "idle_no_req");
        step(1, 0, 0, 6'd0, 6'b000111, 0, 0, 0, "idle_id_stall");

        // len=4: four stalled cycles, done on the fifth, idle on the sixth
        step(0, 1, 0, 6'd4, 6'b001111, 0, 0, 0, "l4_c1");
        step(0, 1, 0, 6'd4, 6'b001111, 0, 0, 1, "l4_c2");
        step(1, 1, 0, 6'd4, 6'b001111, 0, 0, 1, "l4_c3_id_absorbed");
        step(0, 1, 0, 6'd4, 6'b001111, 0, 0, 1, "l4_c4");
        step(0, 1, 0, 6'd4, 6'b000000, 0, 1, 0, "l4_done");
        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "l4_idle");

        // len=1, with an ID hazard visible in the DONE cycle
        step(0, 1, 0, 6'd1, 6'b001111, 0, 0, 0, "l1_c1");
        step(1, 1, 0, 6'd1, 6'b000111, 0, 1, 0, "l1_done_id");
        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "l1_idle");

        // len=0 is single-cycle: no stall, no done
        step(0, 1, 0, 6'd0, 6'b000000, 0, 0, 0, "l0_c1");
        step(0, 1, 0, 6'd0, 6'b000000, 0, 0, 0, "l0_c2");
        step(1, 1, 0, 6'd0, 6'b000111, 0, 0, 0, "l0_id");
        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "l0_idle");

        // len=3 with an ID hazard held throughout
        step(1, 1, 0, 6'd3, 6'b001111, 0, 0, 0, "l3_c1");
        step(1, 1, 0, 6'd3, 6'b001111, 0, 0, 1, "l3_c2");
        step(1, 1, 0, 6'd3, 6'b001111, 0, 0, 1, "l3_c3");
        step(1, 1, 0, 6'd3, 6'b000111, 0, 1, 0, "l3_done_id");
        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "l3_idle");

        // len=5 flushed in its second BUSY cycle
        step(0, 1, 0, 6'd5, 6'b001111, 0, 0, 0, "l5_c1");
        step(0, 1, 0, 6'd5, 6'b001111, 0, 0, 1, "l5_busy1");
        step(1, 1, 1, 6'd5, 6'b000000, 1, 0, 1, "l5_flush");
        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "l5_idle_after_flush");
        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "l5_no_done");

        // flush beats a start in IDLE
        step(0, 1, 1, 6'd4, 6'b000000, 1, 0, 0, "flush_vs_start");
        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "flush_vs_start_next");

        // asynchronous reset between edges mid-BUSY
        step(0, 1, 0, 6'd5, 6'b001111, 0, 0, 0, "arst_c1");
        step(0, 1, 0, 6'd5, 6'b001111, 0, 0, 1, "arst_busy");
        drive(1'b1, 1'b1, 1'b0, 6'd5);
        #2;
        rst = 1'b1;
        #1;
        expect_out(6'b000000, 1'b0, 1'b0, 1'b0);
        check("arst_immediate");
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 6'd0);
        rst = 1'b0;
        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "arst_after1");
        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "arst_no_done");

        // len=63: exactly 63 stalled cycles, no wrap
        step(0, 1, 0, 6'd63, 6'b001111, 0, 0, 0, "l63_c1");
        for (int i = 0; i < 62; i++)
            step(0, 1, 0, 6'd63, 6'b001111, 0, 0, 1, "l63_busy");
        step(0, 1, 0, 6'd63, 6'b000000, 0, 1, 0, "l63_done");
        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "l63_idle");
        step(0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, "l63_still_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
